// File: rtl/fft_frame_buffer_pkg.sv
// Shared constants, bank-state encoding and frame-packing helper for the
// FIR -> frame buffer -> 16-point FFT path.
package fft_frame_buffer_pkg;

  localparam int N_POINT = 16;
  localparam int DW      = 16;
  localparam int PTR_W   = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Lowest bit of sample k inside a flattened frame word (k=0 is the oldest).
  function automatic int unsigned slice_lo(input int unsigned k);
    return k * DW;
  endfunction

endpackage

// File: rtl/fft_frame_buffer_bank.sv
// One N_POINT x DW register file holding a single frame, exposed as a
// flattened parallel word. A write to the same bank in the same cycle as a
// clear wins at its own address, so a freed bank can take sample 0 at once.
module fft_frame_buffer_bank
  import fft_frame_buffer_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DW-1:0]         wdata,
  input  logic                  clr,
  output logic [N_POINT*DW-1:0] rdata
);

  logic [DW-1:0] mem [N_POINT];

  // Sample storage: cleared on reset or release, written one sample at a time.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_POINT; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < N_POINT; i++) begin
        if (we && (waddr == PTR_W'(i))) mem[i] <= wdata;
        else if (clr)                   mem[i] <= '0;
      end
    end
  end

  // Flatten the register file into the frame word, oldest sample lowest.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_POINT; k++) rdata[slice_lo(k) +: DW] = mem[k];
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the FIR and the FFT. One bank fills while
// the other is presented; a full write bank drops samples and sets a sticky
// overflow flag instead of stalling the FIR.
module fft_frame_buffer
  import fft_frame_buffer_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  fir_valid_d,
  input  logic [DW-1:0]         fir_d,
  input  logic                  fft_ready,
  output logic                  fft_valid,
  output logic [N_POINT*DW-1:0] fft_data,
  output logic                  overflow,
  output logic [PTR_W:0]        fill_cnt
);

  bank_state_t            state_q [2];
  bank_state_t            state_d [2];
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic                   handshake;
  logic                   accept;
  logic                   bank_we  [2];
  logic                   bank_clr [2];
  logic [N_POINT*DW-1:0]  bank_rdata [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_buffer_bank u_bank (
      .CLK   (CLK),
      .RST_N (RST_N),
      .we    (bank_we[b]),
      .waddr (wr_ptr_q),
      .wdata (fir_d),
      .clr   (bank_clr[b]),
      .rdata (bank_rdata[b])
    );
  end

  // Ping-pong control: release on handshake, accept or drop the incoming
  // sample, and precompute whether the read bank will be full next cycle.
  always_comb begin
    state_d    = state_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    bank_we    = '{1'b0, 1'b0};
    bank_clr   = '{1'b0, 1'b0};

    handshake = valid_q && fft_ready;
    accept    = fir_valid_d &&
                ((state_q[wr_sel_q] != FULL) || (handshake && (rd_sel_q == wr_sel_q)));

    if (handshake) begin
      state_d[rd_sel_q]  = EMPTY;
      bank_clr[rd_sel_q] = 1'b1;
      rd_sel_d           = ~rd_sel_q;
    end

    if (accept) begin
      bank_we[wr_sel_q] = 1'b1;
      if (wr_ptr_q == PTR_W'(N_POINT - 1)) begin
        state_d[wr_sel_q] = FULL;
        wr_ptr_d          = '0;
        wr_sel_d          = ~wr_sel_q;
      end else begin
        state_d[wr_sel_q] = FILLING;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
    end else if (fir_valid_d) begin
      overflow_d = 1'b1;
    end

    valid_d = (state_d[rd_sel_d] == FULL);
  end

  // Control registers; reset discards every partial and complete frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= '{EMPTY, EMPTY};
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign fft_valid = valid_q;
  assign fft_data  = rd_sel_q ? bank_rdata[1] : bank_rdata[0];
  assign overflow  = overflow_q;
  assign fill_cnt  = {1'b0, wr_ptr_q};

endmodule
